// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the on-chip memory burst front end:
// controller state encoding, Avalon response codes, default geometry
// and the address range helper used when range checking is compiled in.
package onchip_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        WR_BURST = 2'd2
    } burst_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEFAULT_ADDR_W  = 12;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_DEPTH   = 3750;
    localparam int DEFAULT_BURST_W = 4;

    // True when a word address falls inside the implemented memory.
    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < $unsigned(depth);
    endfunction

endpackage

// File: rtl/onchip_mem_burst_front_rd_return_pipe.sv
// One-stage return pipe for read beats: a valid and error flag registered
// alongside the memory address cycle so that they line up with m_readdata
// one cycle later. Error beats return zero data and SLVERR.
module rd_return_pipe
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_err,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        resp
);

    logic valid_q;
    logic err_q;

    // Delay the issue flags by the memory read latency; reset drops any beat in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= issue_valid;
            err_q   <= issue_valid & issue_err;
        end
    end

    // Qualify memory data with the delayed flags so idle and error beats read as zero.
    always_comb begin
        rdata_valid = valid_q;
        rdata       = (valid_q && !err_q) ? mem_rdata : '0;
        resp        = (valid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
    end

endmodule

// File: rtl/onchip_mem_burst_front.sv
// Avalon-MM burst front end for the single-port on-chip memory. Read bursts
// are expanded into one registered memory read per cycle while the slave
// side is stalled; write bursts are passed through beat by beat as the
// master presents them. Read data returns through rd_return_pipe.
// Optional feature macro: ONCHIP_MEM_BURST_ADDR_CHECK_EN enables the
// out-of-range check against DEPTH (suppressed writes, SLVERR reads).
module onchip_mem_burst_front
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int BURST_W = DEFAULT_BURST_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic [BURST_W-1:0]  s_burstcount,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W-1:0]   s_writedata,
    input  logic [DATA_W/8-1:0] s_byteenable,
    output logic                s_waitrequest,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    output logic [1:0]          s_response,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    input  logic [DATA_W-1:0]   m_readdata
);

`ifdef ONCHIP_MEM_BURST_ADDR_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    burst_state_t       state;
    logic [ADDR_W-1:0]  next_addr;
    logic [BURST_W-1:0] beats_left;
    logic [BURST_W-1:0] cmd_len;
    logic               cmd_in_range;
    logic               next_in_range;
    logic               rd_issue;
    logic               rd_err;

    // A zero burstcount behaves as a single beat; without the check every address is in range.
    always_comb begin
        cmd_len       = (s_burstcount == '0) ? BURST_ONE : s_burstcount;
        cmd_in_range  = !CHECK_EN || addr_in_range(32'(s_address), DEPTH);
        next_in_range = !CHECK_EN || addr_in_range(32'(next_addr), DEPTH);
    end

    assign s_waitrequest = (state == RD_ISSUE);
    assign m_clken       = 1'b1;

    // Burst controller: accepts commands in IDLE and drives one registered memory access per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            next_addr    <= '0;
            beats_left   <= '0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            rd_issue     <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            rd_issue     <= 1'b0;
            rd_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_write) begin
                        m_address    <= s_address;
                        m_writedata  <= s_writedata;
                        m_byteenable <= s_byteenable;
                        m_chipselect <= cmd_in_range;
                        m_write      <= 1'b1;
                        next_addr    <= s_address + ADDR_ONE;
                        beats_left   <= cmd_len - BURST_ONE;
                        if (cmd_len > BURST_ONE) begin
                            state <= WR_BURST;
                        end
                    end else if (s_read) begin
                        m_address    <= s_address;
                        m_chipselect <= cmd_in_range;
                        rd_issue     <= 1'b1;
                        rd_err       <= !cmd_in_range;
                        next_addr    <= s_address + ADDR_ONE;
                        beats_left   <= cmd_len - BURST_ONE;
                        if (cmd_len > BURST_ONE) begin
                            state <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    m_address    <= next_addr;
                    m_chipselect <= next_in_range;
                    rd_issue     <= 1'b1;
                    rd_err       <= !next_in_range;
                    next_addr    <= next_addr + ADDR_ONE;
                    beats_left   <= beats_left - BURST_ONE;
                    if (beats_left == BURST_ONE) begin
                        state <= IDLE;
                    end
                end
                WR_BURST: begin
                    if (s_write) begin
                        m_address    <= next_addr;
                        m_writedata  <= s_writedata;
                        m_byteenable <= s_byteenable;
                        m_chipselect <= next_in_range;
                        m_write      <= 1'b1;
                        next_addr    <= next_addr + ADDR_ONE;
                        beats_left   <= beats_left - BURST_ONE;
                        if (beats_left == BURST_ONE) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rd_return_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_return_pipe (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (rd_issue),
        .issue_err   (rd_err),
        .mem_rdata   (m_readdata),
        .rdata_valid (s_readdatavalid),
        .rdata       (s_readdata),
        .resp        (s_response)
    );

endmodule

// File: doc/onchip_mem_burst_front.md
# onchip_mem_burst_front

Avalon-MM burst front end placed directly upstream of the single-port on-chip memory slave, which has a 32-bit word, 12-bit address, 3750 words and a one-cycle read latency. It accepts pipelined read and write bursts from the Nios II data master or the interconnect, using waitrequest and readdatavalid. It expands each burst into one registered single-word access per cycle on the memory port and returns read data with readdatavalid.

## Interface
- ADDR_W, 12, word-address width on both sides
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 3750, number of implemented words
- BURST_W, 4, burstcount width; maximum burst is 2^(BURST_W-1) = 8
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- s_address  in  ADDR_W  burst start word address
- s_burstcount  in  BURST_W  beats in the burst, 1..8
- s_read / s_write  in  1  command strobes
- s_writedata  in  DATA_W  write beat data
- s_byteenable  in  DATA_W/8  write beat byte lanes
- s_waitrequest  out  1  high means the command or beat is not accepted
- s_readdata  out  DATA_W  read beat data
- s_readdatavalid  out  1  read beat valid
- s_response  out  2  2'b00 OKAY, 2'b10 SLVERR; qualified by readdatavalid
- m_address  out  ADDR_W  memory address (registered)
- m_byteenable  out  DATA_W/8  memory byte lanes (registered)
- m_chipselect / m_write  out  1  memory access and write strobe (registered)
- m_writedata  out  DATA_W  memory write data (registered)
- m_clken  out  1  memory clock enable
- m_readdata  in  DATA_W  memory read data, valid one cycle after the address cycle

## Operation
- States:
  - IDLE: s_waitrequest = 0.
  - RD_ISSUE: s_waitrequest = 1.
  - WR_BURST: s_waitrequest = 0; only s_write beats are accepted.
- A command or beat is accepted when the strobe is high and s_waitrequest is low.
- If s_read and s_write are both asserted in IDLE, the write is taken and the read is ignored.
- s_burstcount = 0 is treated as 1.
- Read acceptance in IDLE:
  - latch base address and count;
  - issue beats base+0 .. base+N-1 on consecutive cycles;
  - move to RD_ISSUE when N>1, otherwise stay in IDLE after the single issue.
  - RD_ISSUE returns to IDLE in the cycle of the last issue; a new command is accepted the following cycle.
- Write acceptance in IDLE:
  - beat 0 is written at the base address;
  - move to WR_BURST when N>1, where remaining beats are accepted whenever s_write is high;
  - beat i is written at base+i;
  - return to IDLE after the Nth beat;
  - gaps (s_write low) are allowed and hold the state.
- Address arithmetic is modulo 2^ADDR_W, so the burst address wraps 4095 -> 0.
- m_clken = 1 out of reset.
- Reset: state goes to IDLE.
  - m_chipselect, m_write, s_readdatavalid are 0.
  - m_address, m_byteenable, m_writedata, s_readdata are 0.
  - s_response = 2'b00.
  - A burst in flight when reset asserts is abandoned; no stale readdatavalid follows.

## Timing
- Read: command accepted at cycle T.
  - Beat i address is on the m_ port at T+1+i.
  - s_readdatavalid for beat i is at T+2+i, so readdatavalid is back-to-back.
- Write beat accepted at T: m_chipselect = m_write = 1 at T+1, and the memory updates at the end of T+1.
- Read directly after write: a read issued at T+2 sees the data written at T+1. There is no forwarding; the memory ordering provides this.
- Peak throughput is one word per cycle. There is no turnaround bubble between back-to-back commands of the same kind except the IDLE acceptance cycle.

## Configuration
- ONCHIP_MEM_BURST_ADDR_CHECK_EN defined: beats with address >= DEPTH are out of range.
  - Out-of-range write beats are accepted but m_chipselect stays 0, so nothing is written.
  - Out-of-range read beats still return readdatavalid in their normal slot, with s_readdata = 0 and s_response = 2'b10.
- Macro undefined: no range check. s_response is always 2'b00 and addresses pass through unchanged, aliasing as the memory decodes them.

## Structure
- Package onchip_mem_pkg holds:
  - the state enum (IDLE, RD_ISSUE, WR_BURST);
  - RESP_OKAY and RESP_SLVERR;
  - default ADDR_W, DATA_W, DEPTH and BURST_W constants.
- One sub-module, rd_return_pipe, is a one-stage valid+error register aligning issue to m_readdata. It produces s_readdatavalid, s_readdata and s_response, and is cleared by reset.

## Test plan
- Single read at 0x010 with the memory preloaded to 0xCAFE0010 -> readdatavalid exactly two cycles after acceptance, data 0xCAFE0010, response 00.
- Write burst of 4 at 0x100 (data 0x11..0x44, byteenable 4'hF) with a one-cycle s_write gap after beat 2, then a read burst of 4 at 0x100 -> writes land at 0x100..0x103 in order; four consecutive readdatavalid cycles return 0x11, 0x22, 0x33, 0x44.
- Read burst of 8 at 0xFFE -> m_address sequence 0xFFE, 0xFFF, 0x000 .. 0x005.
  - With the macro: beats at 0xFFE and 0xFFF return data 0 and response 10; the others return 00.
- Byte-lane write of 0xAABBCCDD with byteenable 4'b0101 over 0x00000000 -> readback 0x00BB00DD.
- Reset asserted in the cycle after a burst-of-8 read is accepted -> no readdatavalid afterwards; s_waitrequest is 0 the cycle after reset deasserts.
- s_read and s_write asserted together in IDLE with burstcount 0 -> a single write is performed and no read data is returned.
